// File: rtl/led_pkg.sv
// Shared definitions for the LED matrix frame scheduler: matrix geometry,
// swap-state encoding, column index type and a one-hot column decoder.
package led_pkg;

    localparam int LED_COLS   = 16;
    localparam int LED_LINE_W = 8;
    localparam logic [LED_LINE_W-1:0] LED_OFF = 8'hFF;

    typedef enum logic {
        ACTIVE  = 1'b0,
        PENDING = 1'b1
    } swap_state_e;

    typedef logic [3:0] col_t;

    // One-hot column select for the row pins.
    function automatic logic [LED_COLS-1:0] col_onehot(input col_t c);
        logic [LED_COLS-1:0] r;
        r = {{(LED_COLS-1){1'b0}}, 1'b1} << c;
        return r;
    endfunction

endpackage

// File: rtl/led_tick_gen.sv
// Column dwell divider: tick_o is high for one clock every TICK_DIV clocks
// (on the terminal count); cnt_o is the position within the current dwell,
// 0 on the clock right after a tick.
module led_tick_gen #(
    parameter int TICK_DIV = 1200,
    parameter int CNT_W    = $clog2(TICK_DIV)
) (
    input  logic             clk_in,
    input  logic             rst_in,
    output logic             tick_o,
    output logic [CNT_W-1:0] cnt_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             term_s;

    assign term_s = (cnt_q == CNT_W'(TICK_DIV - 1));

    // Next count: wrap to zero on the terminal count, otherwise increment.
    always_comb begin
        cnt_d = cnt_q;
        if (term_s) begin
            cnt_d = {CNT_W{1'b0}};
        end else begin
            cnt_d = cnt_q + CNT_W'(1'b1);
        end
    end

    // Divider counter register.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            cnt_q <= {CNT_W{1'b0}};
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick_o = term_s;
    assign cnt_o  = cnt_q;

endmodule

// File: rtl/led_frame_sched.sv
// Double-buffered frame scheduler for the 16-column LED matrix.
// Two renderers write columns into the back bank through a round-robin
// arbiter; the front bank is scanned onto row/line. A commit request arms a
// swap that happens only on the frame wrap (column 15 -> 0), and writes are
// stalled while the swap is pending so nothing lands in a bank about to be
// shown.
// Optional build macro LED_SCHED_BLANK_EN: blank line for BLANK_CYC clocks
// at the start of every column to suppress ghosting.
module led_frame_sched
    import led_pkg::*;
#(
    parameter int TICK_DIV  = 1200,
    parameter int BLANK_CYC = 16
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic [1:0]            wr_req,
    input  logic [3:0]            wr_col0,
    input  logic [3:0]            wr_col1,
    input  logic [LED_LINE_W-1:0] wr_dat0,
    input  logic [LED_LINE_W-1:0] wr_dat1,
    output logic [1:0]            wr_ack,
    input  logic                  commit_in,
    output logic                  swap_done,
    output logic [LED_COLS-1:0]   row,
    output logic [LED_LINE_W-1:0] line
);

    localparam int CNT_W = $clog2(TICK_DIV);

    logic [LED_LINE_W-1:0] bank_q [2][LED_COLS];

    swap_state_e           state_q, state_d;
    logic                  last_q, last_d;
    logic                  fsel_q, fsel_d;
    col_t                  col_q, col_d;
    logic [LED_COLS-1:0]   row_q, row_d;
    logic [LED_LINE_W-1:0] line_q, line_d;

    logic                  tick_s;
    logic [CNT_W-1:0]      cnt_s;
    logic                  wrap_s;
    logic                  swap_s;
    logic [1:0]            gnt_s;
    logic                  wr_en_s;
    col_t                  wr_col_s;
    logic [LED_LINE_W-1:0] wr_dat_s;
    logic                  back_sel_s;
    col_t                  col_next_s;
    logic [LED_LINE_W-1:0] front_next_s;

    led_tick_gen #(
        .TICK_DIV (TICK_DIV),
        .CNT_W    (CNT_W)
    ) u_tick (
        .clk_in (clk_in),
        .rst_in (rst_in),
        .tick_o (tick_s),
        .cnt_o  (cnt_s)
    );

    assign wrap_s     = tick_s && (col_q == 4'd15);
    assign back_sel_s = ~fsel_q;
    assign fsel_d     = fsel_q ^ swap_s;
    assign col_next_s = col_q + 4'd1;
    // Front data for the next column, taken from the post-swap bank on a wrap.
    assign front_next_s = bank_q[fsel_d][col_next_s];

    // Round-robin arbiter: grants only while ACTIVE, alternates on contention.
    always_comb begin
        gnt_s  = 2'b00;
        last_d = last_q;
        if (state_q == ACTIVE) begin
            case (wr_req)
                2'b01:   gnt_s = 2'b01;
                2'b10:   gnt_s = 2'b10;
                2'b11: begin
                    if (last_q) begin
                        gnt_s = 2'b01;
                    end else begin
                        gnt_s = 2'b10;
                    end
                    last_d = ~last_q;
                end
                default: gnt_s = 2'b00;
            endcase
        end else begin
            gnt_s = 2'b00;
        end
    end

    // Write port mux for the granted requester.
    always_comb begin
        wr_en_s = |gnt_s;
        if (gnt_s[1]) begin
            wr_col_s = wr_col1;
            wr_dat_s = wr_dat1;
        end else begin
            wr_col_s = wr_col0;
            wr_dat_s = wr_dat0;
        end
    end

    // Swap FSM: commit arms a swap, the next frame wrap performs it.
    always_comb begin
        state_d = state_q;
        swap_s  = 1'b0;
        case (state_q)
            ACTIVE: begin
                if (commit_in) begin
                    state_d = PENDING;
                end else begin
                    state_d = ACTIVE;
                end
            end
            PENDING: begin
                if (wrap_s) begin
                    state_d = ACTIVE;
                    swap_s  = 1'b1;
                end else begin
                    state_d = PENDING;
                end
            end
            default: state_d = ACTIVE;
        endcase
    end

    // Scan next state: advance column and row select on each tick.
    always_comb begin
        col_d = col_q;
        row_d = row_q;
        if (tick_s) begin
            col_d = col_next_s;
            row_d = col_onehot(col_next_s);
        end else begin
            col_d = col_q;
            row_d = row_q;
        end
    end

`ifdef LED_SCHED_BLANK_EN
    // Column data with a blanking window at the start of every dwell.
    always_comb begin
        line_d = line_q;
        if (tick_s) begin
            if (BLANK_CYC > 32'sd0) begin
                line_d = LED_OFF;
            end else begin
                line_d = front_next_s;
            end
        end else if ((int'(cnt_s) + 32'sd1) < BLANK_CYC) begin
            line_d = LED_OFF;
        end else begin
            line_d = bank_q[fsel_q][col_q];
        end
    end
`else
    logic unused_s;
    assign unused_s = (^cnt_s) ^ (BLANK_CYC > 32'sd0);

    // Column data loads on the tick edge and holds for the whole dwell.
    always_comb begin
        line_d = line_q;
        if (tick_s) begin
            line_d = front_next_s;
        end else begin
            line_d = line_q;
        end
    end
`endif

    // Frame bank storage: clear on reset, granted writes go to the back bank.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            for (int b = 0; b < 2; b++) begin
                for (int c = 0; c < LED_COLS; c++) begin
                    bank_q[b][c] <= LED_OFF;
                end
            end
        end else if (wr_en_s) begin
            bank_q[back_sel_s][wr_col_s] <= wr_dat_s;
        end
    end

    // Control and scan output registers.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q <= ACTIVE;
            last_q  <= 1'b1;
            fsel_q  <= 1'b0;
            col_q   <= 4'd0;
            row_q   <= col_onehot(4'd0);
            line_q  <= LED_OFF;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            fsel_q  <= fsel_d;
            col_q   <= col_d;
            row_q   <= row_d;
            line_q  <= line_d;
        end
    end

    assign wr_ack    = gnt_s;
    assign swap_done = swap_s;
    assign row       = row_q;
    assign line      = line_q;

endmodule
